// File: rtl/mux_pipe.sv
// Channel-select mux feeding a 2-entry skid buffer with a delivered-beat counter.
// Optional out-of-range select flag enabled by defining MUX_PIPE_SEL_CHECK_EN.
module mux_pipe #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               xfer_cnt,
  output logic                      sel_err
);

  logic [1:0]       occ;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [WIDTH-1:0] sel_data;
  logic [15:0]      cnt_q;
  logic             push;
  logic             pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = head_q;
  assign xfer_cnt  = cnt_q;

  // A select value with no matching channel leaves the beat all-zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(sel) == i) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // head_q is the oldest beat; tail_q only holds data while two beats are stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
        head_q <= sel_data;
      end else if (pop && occ == 2'd2) begin
        head_q <= tail_q;
      end
      if (push && occ == 2'd1 && !pop) begin
        tail_q <= sel_data;
      end
      if (push && !pop) begin
        occ <= occ + 2'd1;
      end else if (pop && !push) begin
        occ <= occ - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else if (pop) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

`ifdef MUX_PIPE_SEL_CHECK_EN
  logic sel_oor;
  logic err_q;

  assign sel_oor = (int'(sel) >= CHANNELS);
  assign sel_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= push && sel_oor;
    end
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per channel, minimum 1.
REQ-002 SHALL have parameter CHANNELS, default 4: number of selectable input channels, minimum 2.
REQ-003 SHALL have derived localparam SEL_W = clog2(CHANNELS): select field width.
REQ-004 SHALL have port clk  input  1: single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  CHANNELS*WIDTH: packed channels, channel i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port sel  input  SEL_W: channel select, sampled with the input beat.
REQ-008 SHALL have port in_valid  input  1: input beat offered.
REQ-009 SHALL have port in_ready  output  1: block can accept a beat this cycle.
REQ-010 SHALL have port out_data  output  WIDTH: selected data at the head of the buffer.
REQ-011 SHALL have port out_valid  output  1: out_data holds a valid beat.
REQ-012 SHALL have port out_ready  input  1: downstream accepts the beat.
REQ-013 SHALL have port xfer_cnt  output  16: count of delivered output beats.
REQ-014 SHALL have port sel_err  output  1: out-of-range select flag (see Configuration).

Function
REQ-015 SHALL accept a beat when in_valid && in_ready at a rising clk edge, storing in_data[sel*WIDTH +: WIDTH].
REQ-016 SHALL buffer accepted beats in a 2-entry FIFO (skid buffer), occupancy 0, 1 or 2.
REQ-017 SHALL drive in_ready = 1 when occupancy < 2, combinationally from registered occupancy only, never from in_valid or out_ready.
REQ-018 SHALL drive out_valid = 1 when occupancy > 0, with out_data equal to the oldest stored beat.
REQ-019 SHALL have a latency of 1 cycle: a beat accepted at edge N is presented at out_valid/out_data after edge N.
REQ-020 SHALL pop the head when out_valid && out_ready at a rising edge.
REQ-021 SHALL, on simultaneous push and pop at occupancy 1, keep occupancy 1 and present the new beat as head.
REQ-022 SHALL, at occupancy 2, deassert in_ready, so a push cannot coincide with full.
REQ-023 SHALL, at occupancy 0 with out_ready high, ignore out_ready, with no pop and no xfer_cnt increment.
REQ-024 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-025 SHALL sustain 1 beat per cycle with continuous in_valid and out_ready.
REQ-026 SHALL preserve delivery order in acceptance order, with no beat dropped or duplicated.
REQ-027 SHALL increment xfer_cnt by 1 per pop, wrapping 16'hFFFF -> 16'h0000 without a flag.
REQ-028 SHALL store all-zero data for an accepted beat whose sel >= CHANNELS, regardless of macro.

Reset
REQ-029 SHALL, while rst_n is low (asynchronous assertion), force occupancy 0, out_valid 0, out_data 0, xfer_cnt 0 and sel_err 0.
REQ-030 SHALL drive in_ready 1 from the first edge after deassertion, since occupancy is 0.
REQ-031 SHALL discard buffered beats on reset mid-operation, neither delivering nor counting them.
REQ-032 SHALL release rst_n synchronously to clk; the first accept is permitted at the first rising edge with rst_n high.

Configuration
REQ-033 SHALL, with macro MUX_PIPE_SEL_CHECK_EN defined, pulse sel_err high for exactly one cycle after each edge that accepts a beat with sel >= CHANNELS.
REQ-034 SHALL, without MUX_PIPE_SEL_CHECK_EN, tie sel_err to constant 0, with data behaviour per REQ-028 unchanged.

Verification
REQ-035 SHALL verify reset: rst_n=0 mid-stream at occupancy 2 -> out_valid=0, xfer_cnt=0 and in_ready=1 immediately after the first edge post-release.
REQ-036 SHALL verify select: WIDTH=8, CHANNELS=4, in_data=32'hDDCCBBAA, sel=0..3 one beat each, out_ready=1 -> out_data AA, BB, CC, DD on consecutive cycles, xfer_cnt=4.
REQ-037 SHALL verify backpressure: out_ready=0 with 3 offered beats -> 2 accepted, in_ready=0, out_data holds the first beat; out_ready=1 -> remaining beats drain in order.
REQ-038 SHALL verify throughput: 100 back-to-back beats with out_ready=1 -> 100 outputs in 100 consecutive cycles after 1-cycle latency, xfer_cnt=100.
REQ-039 SHALL verify wrap: xfer_cnt driven to 16'hFFFF by streaming, one more pop -> xfer_cnt=16'h0000.
REQ-040 SHALL verify the range check: CHANNELS=3, sel=3 accepted -> out_data=0; sel_err=1 for one cycle with MUX_PIPE_SEL_CHECK_EN, and 0 throughout without it.
